// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register.
// Contents:
//   MODE_* : 3-bit operation codes for the mode input
//   cnt_width(width) : bit width needed for a counter that saturates at width
package usr_pkg;

   localparam logic [2:0] MODE_HOLD  = 3'd0;
   localparam logic [2:0] MODE_LOAD  = 3'd1;
   localparam logic [2:0] MODE_SHL   = 3'd2;
   localparam logic [2:0] MODE_SHR   = 3'd3;
   localparam logic [2:0] MODE_ROL   = 3'd4;
   localparam logic [2:0] MODE_ROR   = 3'd5;
   localparam logic [2:0] MODE_ASR   = 3'd6;
   localparam logic [2:0] MODE_CLEAR = 3'd7;

   // The counter must be able to hold the value width itself, not just width-1.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/dff_en_sr.sv
// Single-bit storage cell with an enable, a synchronous active-low reset and a
// per-instance reset value.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : synchronous active-low reset, loads rst_val
//   en      : capture d when high, otherwise hold
//   rst_val : value taken on reset
//   d       : next-state data
//   q       : stored bit
module dff_en_sr (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic rst_val,
   input  logic d,
   output logic q
);

   // NOTE: sequential state uses non-blocking assignments so every cell samples
   // its neighbours' pre-edge values; blocking here would make shifts race.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= rst_val;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register built from dff_en_sr cells.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset (q = RESET_VAL, shift_cnt = 0)
//   mode      : operation select, see usr_pkg MODE_* codes
//   d         : parallel load data
//   sin_r     : serial input entering bit 0 on SHL
//   sin_l     : serial input entering bit WIDTH-1 on SHR
//   q         : register contents
//   sout_l    : q[WIDTH-1]
//   sout_r    : q[0]
//   shift_cnt : shifts/rotates since last load, clear or reset; saturates at WIDTH
//   drained   : shift_cnt == WIDTH
module universal_shift_reg
   import usr_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [2:0]                     mode,
   input  logic [WIDTH-1:0]               d,
   input  logic                           sin_r,
   input  logic                           sin_l,
   output logic [WIDTH-1:0]               q,
   output logic                           sout_l,
   output logic                           sout_r,
   output logic [cnt_width(WIDTH)-1:0]    shift_cnt,
   output logic                           drained
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

   logic [WIDTH-1:0] q_next;
   logic             load_en;
   logic [CW-1:0]    cnt;

   // NOTE: q_next gets a default before the case so every path assigns it and
   // no latch is inferred.
   always_comb begin
      q_next = q;
      case (mode)
         MODE_LOAD:  q_next = d;
         MODE_SHL:   q_next = {q[WIDTH-2:0], sin_r};
         MODE_SHR:   q_next = {sin_l, q[WIDTH-1:1]};
         MODE_ROL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
         MODE_ROR:   q_next = {q[0], q[WIDTH-1:1]};
         MODE_ASR:   q_next = {q[WIDTH-1], q[WIDTH-1:1]};
         MODE_CLEAR: q_next = '0;
         default:    q_next = q;
      endcase
   end

   // HOLD simply leaves the cells disabled.
   assign load_en = (mode != MODE_HOLD);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      dff_en_sr u_cell (
         .clk     (clk),
         .rst_n   (rst_n),
         .en      (load_en),
         .rst_val (RESET_VAL[i]),
         .d       (q_next[i]),
         .q       (q[i])
      );
   end

   // Counts shifts and rotates since the word was (re)established; saturates
   // so a drained register keeps reporting drained while it keeps rotating.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         case (mode)
            MODE_LOAD, MODE_CLEAR: cnt <= '0;
            MODE_HOLD:             cnt <= cnt;
            default: begin
               if (cnt != CNT_MAX) begin
                  cnt <= cnt + CW'(1);
               end
            end
         endcase
      end
   end

   assign shift_cnt = cnt;
   assign drained   = (cnt == CNT_MAX);
   assign sout_l    = q[WIDTH-1];
   assign sout_r    = q[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg: directed scenarios on an 8-bit
// instance plus randomised runs on 2- and 33-bit instances against a model.
module tb_universal_shift_reg;
   import usr_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // 8-bit instance
   logic       rst_n8 = 1'b0;
   logic [2:0] mode8  = MODE_HOLD;
   logic [7:0] d8     = '0;
   logic       sinr8  = 1'b0;
   logic       sinl8  = 1'b0;
   logic [7:0] q8;
   logic       soutl8, soutr8, dr8;
   logic [3:0] cnt8;

   // 2-bit instance
   localparam logic [1:0] RV2 = 2'b10;
   logic       rst_n2 = 1'b0;
   logic [2:0] mode2  = MODE_HOLD;
   logic [1:0] d2     = '0;
   logic       sinr2  = 1'b0;
   logic       sinl2  = 1'b0;
   logic [1:0] q2;
   logic       soutl2, soutr2, dr2;
   logic [1:0] cnt2;

   // 33-bit instance
   localparam logic [32:0] RV33 = 33'h1_2345_6789;
   logic        rst_n33 = 1'b0;
   logic [2:0]  mode33  = MODE_HOLD;
   logic [32:0] d33     = '0;
   logic        sinr33  = 1'b0;
   logic        sinl33  = 1'b0;
   logic [32:0] q33;
   logic        soutl33, soutr33, dr33;
   logic [5:0]  cnt33;

   universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dut8 (
      .clk(clk), .rst_n(rst_n8), .mode(mode8), .d(d8), .sin_r(sinr8), .sin_l(sinl8),
      .q(q8), .sout_l(soutl8), .sout_r(soutr8), .shift_cnt(cnt8), .drained(dr8));

   universal_shift_reg #(.WIDTH(2), .RESET_VAL(RV2)) u_dut2 (
      .clk(clk), .rst_n(rst_n2), .mode(mode2), .d(d2), .sin_r(sinr2), .sin_l(sinl2),
      .q(q2), .sout_l(soutl2), .sout_r(soutr2), .shift_cnt(cnt2), .drained(dr2));

   universal_shift_reg #(.WIDTH(33), .RESET_VAL(RV33)) u_dut33 (
      .clk(clk), .rst_n(rst_n33), .mode(mode33), .d(d33), .sin_r(sinr33), .sin_l(sinl33),
      .q(q33), .sout_l(soutl33), .sout_r(soutr33), .shift_cnt(cnt33), .drained(dr33));

   // mode must be known at every edge where reset is not asserted
   always @(posedge clk) begin
      if ((rst_n8 === 1'b1 && $isunknown(mode8)) || (rst_n2 === 1'b1 && $isunknown(mode2)) ||
          (rst_n33 === 1'b1 && $isunknown(mode33))) begin
         n_err++;
         $display("FAIL mode_known: mode8=%b mode2=%b mode33=%b required known", mode8, mode2, mode33);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference next-state, expressed as integer shifts on a 64-bit word.
   function automatic logic [63:0] ref_next(input logic [63:0] cur, input int w,
                                            input logic [2:0] m, input logic [63:0] din,
                                            input logic sr, input logic sl);
      logic [63:0] mask;
      logic [63:0] msb;
      logic [63:0] lsb;
      mask = (64'd1 << w) - 64'd1;
      msb  = (cur >> (w - 1)) & 64'd1;
      lsb  = cur & 64'd1;
      case (m)
         3'd0:    return cur;
         3'd1:    return din & mask;
         3'd2:    return ((cur << 1) | 64'(sr)) & mask;
         3'd3:    return (cur >> 1) | (64'(sl) << (w - 1));
         3'd4:    return ((cur << 1) | msb) & mask;
         3'd5:    return (cur >> 1) | (lsb << (w - 1));
         3'd6:    return (cur >> 1) | (msb << (w - 1));
         default: return 64'd0;
      endcase
   endfunction

   function automatic int ref_cnt(input int c, input int w, input logic [2:0] m);
      if (m == 3'd1 || m == 3'd7) return 0;
      if (m == 3'd0) return c;
      return (c + 1 > w) ? w : c + 1;
   endfunction

   task automatic test_reset();
      rst_n8 = 1'b0; mode8 = MODE_HOLD; d8 = 8'h3C;
      tick(); tick();
      n_cmp++; if (q8 !== 8'hA5) begin n_err++; $display("FAIL reset_q: got %h want a5", q8); end
      n_cmp++; if (cnt8 !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", cnt8); end
      n_cmp++; if (dr8 !== 1'b0) begin n_err++; $display("FAIL reset_drained: got %b want 0", dr8); end
      n_cmp++; if (soutl8 !== 1'b1 || soutr8 !== 1'b1) begin
         n_err++; $display("FAIL reset_sout: got l=%b r=%b want l=1 r=1", soutl8, soutr8);
      end
      rst_n8 = 1'b1; mode8 = MODE_CLEAR;
      tick();
      n_cmp++; if (q8 !== 8'h00) begin n_err++; $display("FAIL clear_q: got %h want 00", q8); end
   endtask

   task automatic test_load_shl();
      mode8 = MODE_LOAD; d8 = 8'b1001_0110;
      tick();
      mode8 = MODE_SHL; sinr8 = 1'b1;
      repeat (3) tick();
      n_cmp++; if (q8 !== 8'b1011_0111) begin n_err++; $display("FAIL shl_q: got %b want 10110111", q8); end
      n_cmp++; if (cnt8 !== 4'd3) begin n_err++; $display("FAIL shl_cnt: got %0d want 3", cnt8); end
      n_cmp++; if (soutl8 !== 1'b1) begin n_err++; $display("FAIL shl_soutl: got %b want 1", soutl8); end
      sinr8 = 1'b0;
   endtask

   task automatic test_serialise();
      logic [7:0] word;
      logic [7:0] stream;
      word = 8'hC3;
      mode8 = MODE_LOAD; d8 = word;
      tick();
      mode8 = MODE_SHR; sinl8 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         stream[i] = soutr8;
         if (i == 7) begin
            n_cmp++; if (dr8 !== 1'b0) begin n_err++; $display("FAIL early_drained: got %b want 0", dr8); end
         end
         tick();
      end
      n_cmp++; if (stream !== word) begin n_err++; $display("FAIL ser_stream: got %b want %b (lsb first)", stream, word); end
      n_cmp++; if (q8 !== 8'h00) begin n_err++; $display("FAIL ser_q: got %h want 00", q8); end
      n_cmp++; if (dr8 !== 1'b1) begin n_err++; $display("FAIL ser_drained: got %b want 1", dr8); end
      tick();
      n_cmp++; if (cnt8 !== 4'd8) begin n_err++; $display("FAIL ser_sat: got %0d want 8", cnt8); end
   endtask

   task automatic test_rotate_asr();
      mode8 = MODE_LOAD; d8 = 8'h81; tick();
      mode8 = MODE_ROL; tick();
      n_cmp++; if (q8 !== 8'h03) begin n_err++; $display("FAIL rol: got %h want 03", q8); end
      mode8 = MODE_ROR; tick(); tick();
      n_cmp++; if (q8 !== 8'hC0) begin n_err++; $display("FAIL ror: got %h want c0", q8); end
      n_cmp++; if (cnt8 !== 4'd3) begin n_err++; $display("FAIL rot_cnt: got %0d want 3", cnt8); end
      mode8 = MODE_LOAD; d8 = 8'h90; tick();
      mode8 = MODE_ASR; sinl8 = 1'b0; tick(); tick();
      n_cmp++; if (q8 !== 8'hE4) begin n_err++; $display("FAIL asr: got %h want e4", q8); end
      n_cmp++; if (cnt8 !== 4'd2) begin n_err++; $display("FAIL asr_cnt: got %0d want 2", cnt8); end
   endtask

   task automatic test_hold_priority();
      for (int i = 0; i < 5; i++) begin
         mode8 = MODE_HOLD; d8 = 8'($urandom); sinl8 = ~sinl8; sinr8 = ~sinr8;
         tick();
         n_cmp++; if (q8 !== 8'hE4 || cnt8 !== 4'd2) begin
            n_err++; $display("FAIL hold_%0d: got q=%h cnt=%0d want q=e4 cnt=2", i, q8, cnt8);
         end
      end
      rst_n8 = 1'b0; mode8 = MODE_LOAD; d8 = 8'hFF;
      tick();
      n_cmp++; if (q8 !== 8'hA5 || cnt8 !== 4'd0) begin
         n_err++; $display("FAIL rst_priority: got q=%h cnt=%0d want q=a5 cnt=0", q8, cnt8);
      end
      rst_n8 = 1'b1; mode8 = MODE_HOLD;
   endtask

   task automatic test_width_sweep();
      logic [63:0] mq2, mq33, e2, e33;
      int          mc2, mc33, ec2, ec33;
      logic        r2, r33;
      bit          sat2, sat33;
      mq2 = 0; mq33 = 0; mc2 = 0; mc33 = 0; sat2 = 0; sat33 = 0;
      for (int i = 0; i < 360; i++) begin
         r2  = (i == 0) || ($urandom_range(0, 19) == 0 && i < 300);
         r33 = (i == 0) || ($urandom_range(0, 19) == 0 && i < 300);
         if (i < 300) begin
            mode2 = 3'($urandom); mode33 = 3'($urandom);
         end else if (i == 300) begin
            mode2 = MODE_LOAD; mode33 = MODE_LOAD;
         end else begin
            mode2 = 3'($urandom_range(2, 6)); mode33 = 3'($urandom_range(2, 6));
         end
         d2 = 2'($urandom); d33 = 33'({$urandom(), $urandom()});
         sinr2 = 1'($urandom); sinl2 = 1'($urandom);
         sinr33 = 1'($urandom); sinl33 = 1'($urandom);
         rst_n2 = ~r2; rst_n33 = ~r33;
         e2   = r2  ? 64'(RV2)  : ref_next(mq2, 2, mode2, 64'(d2), sinr2, sinl2);
         ec2  = r2  ? 0 : ref_cnt(mc2, 2, mode2);
         e33  = r33 ? 64'(RV33) : ref_next(mq33, 33, mode33, 64'(d33), sinr33, sinl33);
         ec33 = r33 ? 0 : ref_cnt(mc33, 33, mode33);
         tick();
         n_cmp++; if (64'(q2) !== e2 || int'(cnt2) !== ec2 || dr2 !== (ec2 == 2)) begin
            n_err++; $display("FAIL w2_cyc%0d: got q=%h cnt=%0d dr=%b want q=%h cnt=%0d dr=%b",
                              i, q2, cnt2, dr2, e2, ec2, ec2 == 2);
         end
         n_cmp++; if (64'(q33) !== e33 || int'(cnt33) !== ec33 || dr33 !== (ec33 == 33)) begin
            n_err++; $display("FAIL w33_cyc%0d: got q=%h cnt=%0d dr=%b want q=%h cnt=%0d dr=%b",
                              i, q33, cnt33, dr33, e33, ec33, ec33 == 33);
         end
         if (i > 300 && int'(cnt2) == 2 && ec2 == 2 && mc2 == 2) sat2 = 1;
         if (i > 300 && int'(cnt33) == 33 && ec33 == 33 && mc33 == 33) sat33 = 1;
         mq2 = e2; mq33 = e33; mc2 = ec2; mc33 = ec33;
      end
      n_cmp++; if (!sat2) begin n_err++; $display("FAIL w2_saturate: got no held count of 2 want held at 2"); end
      n_cmp++; if (!sat33) begin n_err++; $display("FAIL w33_saturate: got no held count of 33 want held at 33"); end
      rst_n2 = 1'b1; rst_n33 = 1'b1; mode2 = MODE_HOLD; mode33 = MODE_HOLD;
   endtask

   initial begin
      test_reset();
      test_load_shl();
      test_serialise();
      test_rotate_asr();
      test_hold_priority();
      test_width_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
